// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one add cell, LSB first.
// Operands load on the start handshake; the result is held until taken.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [CNT_W-1:0] bit_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;

  logic st_idle, st_run, st_done;
  logic p, g, s, t, c_nxt;

  assign st_idle = (state_q == S_IDLE);
  assign st_run  = (state_q == S_RUN);
  assign st_done = (state_q == S_DONE);

  // Two half adders around the registered carry
  assign p     = a_sr_q[0] ^ b_sr_q[0];
  assign g     = a_sr_q[0] & b_sr_q[0];
  assign s     = p ^ carry_q;
  assign t     = p & carry_q;
  assign c_nxt = g | t;

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    bit_idx_d = bit_idx_q;
    unique case (1'b1)
      st_idle: begin
        if (start_valid) begin
          a_sr_d    = op_a;
          b_sr_d    = op_b;
          carry_d   = cin;
          bit_idx_d = '0;
          sum_d     = '0;
          cout_d    = 1'b0;
          state_d   = S_RUN;
        end
      end
      st_run: begin
        sum_d   = {s, sum_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_nxt;
        if (bit_idx_q == LAST) begin
          cout_d    = c_nxt;
          bit_idx_d = '0;
          state_d   = S_DONE;
        end else begin
          bit_idx_d = bit_idx_q + CNT_W'(1);
        end
      end
      st_done: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign start_ready = st_idle;
  assign done_valid  = st_done;
  assign busy        = st_run | st_done;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign bit_idx     = bit_idx_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8).
// Expected {cout,sum} queued at accept, popped on done handshake.
module tb_serial_add_ctrl;
  localparam int W = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          cin = 1'b0;
  logic          done_valid;
  logic          done_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
  logic [CW-1:0] bit_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [W:0] sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .done_valid(done_valid), .done_ready(done_ready),
    .sum(sum), .cout(cout),
    .busy(busy), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed result against the scoreboard
  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got %0h want none", {cout, sum});
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("result", 32'({cout, sum}), 32'(e));
      end
    end
  end

  function automatic logic [W:0] ref_add(logic [W-1:0] a,
                                         logic [W-1:0] b,
                                         logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Present an op and return once it has been accepted
  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic c,
                       bit push);
    int k;
    k = 0;
    @(negedge clk);
    while (!start_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!start_ready) chk("accept_timeout", 0, 1);
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    if (push) sb.push_back(ref_add(a, b, c));
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!done_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done_valid) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int acc_prev;
    int k;
    logic [W-1:0] ra, rb;
    logic rc;

    #3;
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_bit_idx", 32'(bit_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3C+5A: latency and bit_idx walk
    issue(8'h3C, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("walk_bit_idx", 32'(bit_idx), 32'(i));
      chk("walk_busy", 32'(busy), 1);
      chk("walk_no_done", 32'(done_valid), 0);
    end
    @(negedge clk);
    chk("latency_done", 32'(done_valid), 1);
    chk("done_sum_96", 32'(sum), 32'h96);
    @(negedge clk);
    chk("idle_after_done", 32'(start_ready), 1);
    chk("done_dropped", 32'(done_valid), 0);

    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done();
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done();

    // Input noise during RUN must not disturb the result
    issue(8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start_valid = ~start_valid;
      op_a = W'($urandom);
      op_b = W'($urandom);
      cin = ~cin;
      chk("run_no_ready", 32'(start_ready), 0);
    end
    start_valid = 1'b0;
    wait_done();

    // Consumer stall in DONE
    @(posedge clk);
    #1 done_ready = 1'b0;
    issue(8'h80, 8'h80, 1'b0, 1'b1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(done_valid), 1);
      chk("stall_sum", 32'(sum), 0);
      chk("stall_cout", 32'(cout), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_valid", 32'(done_valid), 0);
    chk("stall_release_ready", 32'(start_ready), 1);

    // Async reset in the middle of a run
    issue(8'h55, 8'h33, 1'b0, 1'b0);
    k = 0;
    @(negedge clk);
    while (bit_idx != 3'd3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_bit3", 32'(bit_idx), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", 32'(done_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_start_ready", 32'(start_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done();

    // Back-to-back with start_valid and done_ready held high
    @(posedge clk);
    #1;
    acc_prev = -1;
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      k = 0;
      @(negedge clk);
      while (!start_ready && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (!start_ready) chk("b2b_timeout", 0, 1);
      op_a = ra; op_b = rb; cin = rc;
      start_valid = 1'b1;
      sb.push_back(ref_add(ra, rb, rc));
      if (acc_prev >= 0) chk("b2b_spacing", 32'(cyc - acc_prev), W + 2);
      acc_prev = cyc;
      @(posedge clk);
    end
    #1 start_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
